// File: rtl/approx_max_stream_if.sv
// Purpose: sample-in / frame-result-out bundle for approx_max_stream.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready handshakes on both sides.
// Ports: in_valid/in_ready/in_data/in_last carry samples toward the block;
//        out_valid/out_ready/out_val/out_idx/out_ovf carry per-frame results away.
//        slave = the block's view, master = the source/consumer view.
interface approx_max_stream_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_val;
    logic [IDX_W-1:0] out_idx;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_val, out_idx, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_val, out_idx, out_ovf
    );
endinterface

// File: rtl/approx_max_stream.sv
// Purpose: per-frame max (or min) of an unsigned sample stream, with position and overflow flag.
// Latency: result on out_* the cycle after the in_last sample is accepted; one sample per cycle.
// Backpressure: in_ready = !out_valid | out_ready; only a held, undelivered result stalls input.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the sample
//        handshake (in_valid/in_ready/in_data/in_last) and the result handshake
//        (out_valid/out_ready/out_val/out_idx/out_ovf).
module approx_max_stream #(
    parameter int WIDTH      = 8,
    parameter int IDX_W      = 8,
    parameter int APPROX_LSB = 0,
    parameter bit MIN_MODE   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    approx_max_stream_if.slave   bus
);

    // Comparator only looks at the bits above APPROX_LSB.
    localparam logic [WIDTH-1:0] KEY_MASK = {WIDTH{1'b1}} << APPROX_LSB;
    localparam logic [IDX_W-1:0] POS_MAX  = {IDX_W{1'b1}};

    // Accumulator
    logic [WIDTH-1:0] best;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] pos;
    logic             ovf;
    logic             first;
    // pos alone cannot tell "next index is the last one" from "last index
    // already used"; sat marks the latter so the next accept raises ovf.
    logic             sat;

    // Output register
    logic             out_valid_q;
    logic [WIDTH-1:0] out_val_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_ovf_q;

    logic             accept;
    logic [WIDTH-1:0] key_in;
    logic [WIDTH-1:0] key_best;
    logic             wins;
    logic [WIDTH-1:0] nxt_best;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] nxt_pos;
    logic             nxt_ovf;
    logic             nxt_sat;

    assign bus.in_ready  = !out_valid_q | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_ovf   = out_ovf_q;

    // Next accumulator contents if the current sample is accepted. The result
    // register is loaded from these too, so the last sample takes part.
    always_comb begin
        key_in   = bus.in_data & KEY_MASK;
        key_best = best & KEY_MASK;
        wins     = 1'b0;
        nxt_best = best;
        nxt_idx  = best_idx;
        nxt_pos  = pos;
        nxt_ovf  = ovf;
        nxt_sat  = sat;

        if (MIN_MODE) begin
            wins = (key_in < key_best);
        end else begin
            wins = (key_in > key_best);
        end

        if (first) begin
            // First sample of a frame loads unconditionally.
            nxt_best = bus.in_data;
            nxt_idx  = '0;
            nxt_pos  = IDX_W'(1);
            nxt_ovf  = 1'b0;
            nxt_sat  = 1'b0;
        end else begin
            if (wins) begin
                nxt_best = bus.in_data;
                nxt_idx  = pos;
            end
            nxt_ovf = ovf | sat;
            if (pos == POS_MAX) begin
                nxt_sat = 1'b1;
            end else begin
                nxt_pos = pos + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best        <= '0;
            best_idx    <= '0;
            pos         <= '0;
            ovf         <= 1'b0;
            first       <= 1'b1;
            sat         <= 1'b0;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            out_idx_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                if (bus.in_last) begin
                    best     <= '0;
                    best_idx <= '0;
                    pos      <= '0;
                    ovf      <= 1'b0;
                    first    <= 1'b1;
                    sat      <= 1'b0;
                end else begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    pos      <= nxt_pos;
                    ovf      <= nxt_ovf;
                    first    <= 1'b0;
                    sat      <= nxt_sat;
                end
            end

            // A new result wins over a handoff in the same cycle: the register
            // reloads and out_valid stays high, so there is no bubble.
            if (accept && bus.in_last) begin
                out_valid_q <= 1'b1;
                out_val_q   <= nxt_best;
                out_idx_q   <= nxt_idx;
                out_ovf_q   <= nxt_ovf;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_approx_max_stream.sv
// Purpose: self-checking bench driving four parameterisations of approx_max_stream with one shared stream.
// Latency: checks result visibility one cycle after the last sample.
// Backpressure: exercises held results with out_ready low and same-cycle reload.
module tb_approx_max_stream;

    typedef struct packed {
        logic [3:0][7:0] val;
        logic [3:0][7:0] idx;
        logic [3:0]      ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    always #5 clk = ~clk;

    // d0: exact max, d1: max ignoring 2 LSBs, d2: exact min, d3: exact max with 2-bit index
    approx_max_stream_if #(.WIDTH(8), .IDX_W(8)) if0 ();
    approx_max_stream_if #(.WIDTH(8), .IDX_W(8)) if1 ();
    approx_max_stream_if #(.WIDTH(8), .IDX_W(8)) if2 ();
    approx_max_stream_if #(.WIDTH(8), .IDX_W(2)) if3 ();

    approx_max_stream #(.WIDTH(8), .IDX_W(8), .APPROX_LSB(0), .MIN_MODE(1'b0)) d0 (.clk(clk), .rst(rst), .bus(if0));
    approx_max_stream #(.WIDTH(8), .IDX_W(8), .APPROX_LSB(2), .MIN_MODE(1'b0)) d1 (.clk(clk), .rst(rst), .bus(if1));
    approx_max_stream #(.WIDTH(8), .IDX_W(8), .APPROX_LSB(0), .MIN_MODE(1'b1)) d2 (.clk(clk), .rst(rst), .bus(if2));
    approx_max_stream #(.WIDTH(8), .IDX_W(2), .APPROX_LSB(0), .MIN_MODE(1'b0)) d3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
    assign if0.in_last  = in_last;   assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
    assign if1.in_last  = in_last;   assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_data = in_data;
    assign if2.in_last  = in_last;   assign if2.out_ready = out_ready;
    assign if3.in_valid = in_valid;  assign if3.in_data = in_data;
    assign if3.in_last  = in_last;   assign if3.out_ready = out_ready;

    logic [3:0]      ov, ir, oovf;
    logic [3:0][7:0] oval, oidx;

    assign ov   = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign ir   = {if3.in_ready,  if2.in_ready,  if1.in_ready,  if0.in_ready};
    assign oovf = {if3.out_ovf,   if2.out_ovf,   if1.out_ovf,   if0.out_ovf};
    assign oval = {if3.out_val,   if2.out_val,   if1.out_val,   if0.out_val};
    assign oidx = {{6'b0, if3.out_idx}, if2.out_idx, if1.out_idx, if0.out_idx};

    int checks = 0;
    int errors = 0;

    exp_t       sbq[$];
    logic [7:0] frm[$];

    int LSB[4] = '{0, 2, 0, 0};
    bit MN[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    int CAP[4] = '{256, 256, 256, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: scan the buffered frame for each parameter set.
    function automatic exp_t model();
        exp_t e;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] msk, best, key, bkey;
            int         bi;
            logic       win;
            msk  = 8'hFF << LSB[k];
            best = 8'h00;
            bi   = 0;
            for (int i = 0; i < frm.size(); i++) begin
                key  = frm[i] & msk;
                bkey = best & msk;
                win  = MN[k] ? (key < bkey) : (key > bkey);
                if (i == 0 || win) begin
                    best = frm[i];
                    bi   = (i > CAP[k] - 1) ? CAP[k] - 1 : i;
                end
            end
            e.val[k] = best;
            e.idx[k] = 8'(bi);
            e.ovf[k] = (frm.size() > CAP[k]);
        end
        return e;
    endfunction

    task automatic send(input logic [7:0] d, input logic l);
        int   n;
        logic acc;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ir[0];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("accept", 32'(acc), 32'd1);
        if (acc) begin
            frm.push_back(d);
            if (l) begin
                e = model();
                sbq.push_back(e);
                frm.delete();
                chk("lat_vld", 32'(ov), 32'hF);
                chk("lat_val", oval, e.val);
                chk("lat_idx", oidx, e.idx);
                chk("lat_ovf", 32'(oovf), 32'(e.ovf));
            end
        end
    endtask

    // Scoreboard pop on every handoff.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov[0] && out_ready) begin
            checks++;
            assert (sbq.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", oval);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_vld", 32'(ov), 32'hF);
                chk("sb_val", oval, e.val);
                chk("sb_idx", oidx, e.idx);
                chk("sb_ovf", 32'(oovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 32'(ov), 32'h0);
        chk("rst_val", oval, 32'h0);
        chk("rst_idx", oidx, 32'h0);
        chk("rst_ovf", 32'(oovf), 32'h0);
        chk("rst_rdy", 32'(ir), 32'hF);
        rst = 1'b0;

        // Basic max / approximate tie / min
        send(8'h10, 1'b0); send(8'h13, 1'b0); send(8'h12, 1'b1);

        // Min frame with repeated minimum, then back-to-back single-sample frames
        send(8'h40, 1'b0); send(8'h05, 1'b0); send(8'h05, 1'b0); send(8'h80, 1'b1);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b1);

        // Index saturation / overflow on the 2-bit index instance, then a clean frame
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
        send(8'd4, 1'b0); send(8'd9, 1'b0); send(8'd5, 1'b1);
        send(8'd7, 1'b0); send(8'd8, 1'b1);
        @(posedge clk); #1;

        // Backpressure: result held, input blocked, junk data ignored
        out_ready = 1'b0;
        send(8'h21, 1'b0); send(8'h22, 1'b1);
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hE0 + 8'(i);
            @(posedge clk); #1;
            chk("hold_rdy", 32'(ir), 32'h0);
            chk("hold_vld", 32'(ov), 32'hF);
            chk("hold_val", oval, (sbq.size() != 0) ? sbq[0].val : 32'hx);
            chk("hold_idx", oidx, (sbq.size() != 0) ? sbq[0].idx : 32'hx);
        end
        out_ready = 1'b1;
        send(8'h30, 1'b1);

        // Reset mid-frame discards the partial frame
        send(8'hFF, 1'b0);
        rst = 1'b1;
        frm.delete();
        sbq.delete();
        @(posedge clk); #1;
        chk("midrst_vld", 32'(ov), 32'h0);
        chk("midrst_rdy", 32'(ir), 32'hF);
        rst = 1'b0;
        send(8'h01, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("drained", 32'(sbq.size()), 32'd0);
        chk("idle_vld", 32'(ov), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
